// File: rtl/fhn_pkg.sv
// Shared types and constants for the FHN spike detector: Q4.12 scaling,
// default thresholds, detector state encoding and the event record layout.
package fhn_pkg;

  localparam int unsigned FRAC_BITS = 12;
  localparam int unsigned ONE       = 1 << FRAC_BITS;

  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_CW = 16;

  // Default hysteresis band: rise at +1.0, fall at 0.0
  localparam logic signed [DEF_DW-1:0] DEF_TH_HI = DEF_DW'(ONE);
  localparam logic signed [DEF_DW-1:0] DEF_TH_LO = '0;

  typedef enum logic [1:0] {
    ST_BELOW   = 2'd0,
    ST_ABOVE   = 2'd1,
    ST_REFRACT = 2'd2
  } fhn_state_e;

  typedef struct packed {
    logic                     first;
    logic [DEF_CW-1:0]        isi;
    logic signed [DEF_DW-1:0] peak;
  } fhn_event_t;

endpackage

// File: rtl/fhn_event_fifo.sv
// Small synchronous FIFO for spike events; extra pointer bit separates full from empty.
module fhn_event_fifo
  import fhn_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1 + DEF_CW + DEF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is legal then
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fhn_spike_detector.sv
// Turns the Q4.12 membrane trace into spike events with hysteresis and refractory
// hold-off, measuring ISI and peak per spike and queueing one event per spike.
module fhn_spike_detector
  import fhn_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned REFRACT = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] v_in,
  input  logic                 v_valid,
  input  logic signed [DW-1:0] th_hi,
  input  logic signed [DW-1:0] th_lo,
  output logic                 spike,
  output logic [CW-1:0]        spike_count,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [CW-1:0]        ev_isi,
  output logic signed [DW-1:0] ev_peak,
  output logic                 ev_first,
  output logic                 overflow
);

  localparam int unsigned EW = 1 + CW + DW;
  localparam int unsigned RW = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

  fhn_state_e           state_q, state_d;
  logic                 spike_q, spike_d;
  logic [CW-1:0]        spike_count_q, spike_count_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        isi_q, isi_d;
  logic signed [DW-1:0] peak_q, peak_d;
  logic                 first_q, first_d;
  logic [RW-1:0]        ref_q, ref_d;
  logic                 push_q, push_d;
  logic [EW-1:0]        ev_q, ev_d;
  logic                 overflow_q, overflow_d;

  logic [CW-1:0]        cnt_inc;
  logic [CW-1:0]        spike_count_inc;
  logic signed [DW-1:0] peak_max;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [EW-1:0]        fifo_dout;

  // Detector: only v_valid samples advance the state, counters or peak tracker
  always_comb begin
    state_d       = state_q;
    spike_d       = 1'b0;
    spike_count_d = spike_count_q;
    cnt_d         = cnt_q;
    isi_d         = isi_q;
    peak_d        = peak_q;
    first_d       = first_q;
    ref_d         = ref_q;
    push_d        = 1'b0;
    ev_d          = ev_q;

    cnt_inc         = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    spike_count_inc = (spike_count_q == '1) ? spike_count_q : spike_count_q + CW'(1);
    peak_max        = (v_in > peak_q) ? v_in : peak_q;

    if (v_valid) begin
      unique case (state_q)
        ST_BELOW: begin
          if (v_in >= th_hi) begin
            state_d       = ST_ABOVE;
            spike_d       = 1'b1;
            spike_count_d = spike_count_inc;
            isi_d         = cnt_inc;
            cnt_d         = '0;
            peak_d        = v_in;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_ABOVE: begin
          cnt_d  = cnt_inc;
          peak_d = peak_max;
          // The falling sample still takes part in the peak comparison
          if (v_in < th_lo) begin
            push_d  = 1'b1;
            ev_d    = {first_q, isi_q, peak_max};
            first_d = 1'b0;
            if (REFRACT > 0) begin
              state_d = ST_REFRACT;
              ref_d   = RW'(REFRACT);
            end else begin
              state_d = ST_BELOW;
            end
          end
        end

        ST_REFRACT: begin
          cnt_d = cnt_inc;
          if (ref_q <= RW'(1)) begin
            state_d = ST_BELOW;
          end else begin
            ref_d = ref_q - RW'(1);
          end
        end

        default: begin
          state_d = ST_BELOW;
        end
      endcase
    end
  end

  // Sticky overflow: a registered push lost because the FIFO was full with no pop
  always_comb begin
    overflow_d = overflow_q | (push_q & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BELOW;
      spike_q       <= 1'b0;
      spike_count_q <= '0;
      cnt_q         <= '0;
      isi_q         <= '0;
      peak_q        <= '0;
      first_q       <= 1'b1;
      ref_q         <= '0;
      push_q        <= 1'b0;
      ev_q          <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      spike_q       <= spike_d;
      spike_count_q <= spike_count_d;
      cnt_q         <= cnt_d;
      isi_q         <= isi_d;
      peak_q        <= peak_d;
      first_q       <= first_d;
      ref_q         <= ref_d;
      push_q        <= push_d;
      ev_q          <= ev_d;
      overflow_q    <= overflow_d;
    end
  end

  assign fifo_pop = ~fifo_empty & ev_ready;

  fhn_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (ev_q),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign spike                       = spike_q;
  assign spike_count                 = spike_count_q;
  assign overflow                    = overflow_q;
  assign ev_valid                    = ~fifo_empty;
  assign {ev_first, ev_isi, ev_peak} = fifo_dout;

endmodule

// File: tb/tb_fhn_spike_detector.sv
// Bench for fhn_spike_detector: an event-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fhn_spike_detector;

  localparam int unsigned DW      = 16;
  localparam int unsigned CW      = 16;
  localparam int unsigned REFRACT = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int          CMAX    = 65535;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] v_in;
  logic                 v_valid;
  logic signed [DW-1:0] th_hi;
  logic signed [DW-1:0] th_lo;
  logic                 spike;
  logic [CW-1:0]        spike_count;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [CW-1:0]        ev_isi;
  logic signed [DW-1:0] ev_peak;
  logic                 ev_first;
  logic                 overflow;

  always #5 clk = ~clk;

  fhn_spike_detector #(
    .DW      (DW),
    .CW      (CW),
    .REFRACT (REFRACT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .v_in        (v_in),
    .v_valid     (v_valid),
    .th_hi       (th_hi),
    .th_lo       (th_lo),
    .spike       (spike),
    .spike_count (spike_count),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_isi      (ev_isi),
    .ev_peak     (ev_peak),
    .ev_first    (ev_first),
    .overflow    (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: spike events as records in a queue, with the one-cycle
  // hand-off from detection to the queue held in 'pend'.
  typedef struct {
    int isi;
    int peak;
    bit first;
  } mev_t;

  mev_t mq[$];
  mev_t pend_ev;
  bit   pend;
  bit   m_armed_off;   // 1 while v is above the band (waiting to fall)
  int   m_hold;        // refractory samples still to skip
  int   m_since;       // samples since last spike (or reset)
  int   m_isi;
  int   m_peak;
  bit   m_first;
  bit   m_spike;
  int   m_count;
  bit   m_ovf;

  always @(posedge clk or posedge rst) begin
    int  sz;
    bit  popped;
    bit  np;
    int  v;
    int  thh;
    int  thl;
    if (rst) begin
      mq.delete();
      pend        = 1'b0;
      m_armed_off = 1'b0;
      m_hold      = 0;
      m_since     = 0;
      m_isi       = 0;
      m_peak      = 0;
      m_first     = 1'b1;
      m_spike     = 1'b0;
      m_count     = 0;
      m_ovf       = 1'b0;
    end else begin
      sz     = mq.size();
      popped = (sz > 0) && ev_ready;
      if (popped) void'(mq.pop_front());
      if (pend) begin
        if (sz < DEPTH || popped) mq.push_back(pend_ev);
        else m_ovf = 1'b1;
      end
      np      = 1'b0;
      m_spike = 1'b0;
      if (v_valid) begin
        v   = v_in;
        thh = th_hi;
        thl = th_lo;
        if (m_hold > 0) begin
          m_hold--;
          m_since = (m_since >= CMAX) ? CMAX : m_since + 1;
        end else if (!m_armed_off) begin
          if (v >= thh) begin
            m_armed_off = 1'b1;
            m_spike     = 1'b1;
            m_count     = (m_count >= CMAX) ? CMAX : m_count + 1;
            m_isi       = (m_since >= CMAX) ? CMAX : m_since + 1;
            m_since     = 0;
            m_peak      = v;
          end else begin
            m_since = (m_since >= CMAX) ? CMAX : m_since + 1;
          end
        end else begin
          m_since = (m_since >= CMAX) ? CMAX : m_since + 1;
          if (v > m_peak) m_peak = v;
          if (v < thl) begin
            np          = 1'b1;
            pend_ev     = '{m_isi, m_peak, m_first};
            m_first     = 1'b0;
            m_armed_off = 1'b0;
            m_hold      = REFRACT;
          end
        end
      end
      pend = np;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("spike", spike, m_spike);
      chk("spike_count", spike_count, m_count);
      chk("overflow", overflow, m_ovf);
      chk("ev_valid", ev_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("ev_isi", ev_isi, mq[0].isi);
        chk("ev_peak", longint'($signed(ev_peak)), mq[0].peak);
        chk("ev_first", ev_first, mq[0].first);
      end else begin
        chk("ev_isi_idle", ev_isi, 0);
        chk("ev_peak_idle", longint'($signed(ev_peak)), 0);
        chk("ev_first_idle", ev_first, 0);
      end
    end
  end

  task automatic step(input int v, input bit vv, input bit rdy);
    @(negedge clk);
    v_in     = DW'(v);
    v_valid  = vv;
    ev_ready = rdy;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst      = 1'b1;
    v_valid  = 1'b0;
    ev_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_check(input string nm, input int isi, input int peak, input bit first);
    settle();
    chk({nm, "_valid"}, ev_valid, 1);
    chk({nm, "_isi"}, ev_isi, isi);
    chk({nm, "_peak"}, longint'($signed(ev_peak)), peak);
    chk({nm, "_first"}, ev_first, first);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
  endtask

  // One spike then a fall: 10 valid samples per spike with REFRACT=8
  task automatic spike_once();
    step(8192, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(-100, 1'b1, 1'b0);
  endtask

  initial begin
    int v;
    int pops;
    rst      = 1'b1;
    v_in     = '0;
    v_valid  = 1'b0;
    ev_ready = 1'b0;
    th_hi    = 16'sd4096;
    th_lo    = 16'sd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Ramp up and down through the band: a single spike with peak 8192
    for (v = -4915; v < 8192; v += 512) step(v, 1'b1, 1'b0);
    step(8192, 1'b1, 1'b0);
    for (v = 8192 - 512; v > -4915; v -= 512) step(v, 1'b1, 1'b0);
    step(-4915, 1'b1, 1'b0);
    repeat (3) step(0, 1'b0, 1'b0);
    settle();
    chk("ramp_count", spike_count, 1);
    chk("ramp_ev_valid", ev_valid, 1);
    chk("ramp_peak", longint'($signed(ev_peak)), 8192);
    chk("ramp_first", ev_first, 1);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
    settle();
    chk("ramp_drained", ev_valid, 0);

    // Periodic trace, period 100 valid samples
    do_reset(2);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 100; i++) step((i < 20) ? 8192 : -4096, 1'b1, 1'b0);
    repeat (3) step(0, 1'b0, 1'b0);
    settle();
    chk("period_count", spike_count, 3);
    pop_check("period_ev1", 1, 8192, 1'b1);
    pop_check("period_ev2", 100, 8192, 1'b0);
    pop_check("period_ev3", 100, 8192, 1'b0);

    // Noise around th_hi: hysteresis keeps it to one spike and no event
    do_reset(2);
    for (int i = 0; i < 40; i++) step((i % 2 == 1) ? 4200 : 4000, 1'b1, 1'b0);
    settle();
    chk("noise_count", spike_count, 1);
    chk("noise_no_event", ev_valid, 0);
    step(-100, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    settle();
    chk("noise_event", ev_valid, 1);
    chk("noise_peak", longint'($signed(ev_peak)), 4200);

    // Crossings during the refractory window are ignored
    do_reset(2);
    step(8192, 1'b1, 1'b0);
    step(-100, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(8192, 1'b1, 1'b0);
    settle();
    chk("refract_hold_count", spike_count, 1);
    step(8192, 1'b1, 1'b0);
    settle();
    chk("refract_after_count", spike_count, 2);
    chk("refract_after_spike", spike, 1);

    // Six spikes into a 4-deep FIFO with no consumer
    do_reset(2);
    for (int k = 0; k < 6; k++) spike_once();
    repeat (3) step(0, 1'b0, 1'b0);
    settle();
    chk("ovf_count", spike_count, 6);
    chk("ovf_flag", overflow, 1);
    pop_check("ovf_ev1", 1, 8192, 1'b1);
    pop_check("ovf_ev2", 10, 8192, 1'b0);
    pop_check("ovf_ev3", 10, 8192, 1'b0);
    pop_check("ovf_ev4", 10, 8192, 1'b0);
    settle();
    chk("ovf_drained", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Push landing on the same cycle as a pop while full is kept
    do_reset(2);
    for (int k = 0; k < 4; k++) spike_once();
    step(8192, 1'b1, 1'b0);
    step(-100, 1'b1, 1'b0);
    step(-100, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(-100, 1'b1, 1'b0);
    settle();
    chk("same_cycle_no_ovf", overflow, 0);
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      if (ev_valid) begin
        pops++;
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0);
        settle();
      end
    end
    chk("same_cycle_drain", pops, 4);

    // Randomized trace with occasional threshold changes
    do_reset(2);
    v = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        th_hi = DW'(int'($urandom_range(0, 8000)) - 2000);
        th_lo = DW'(int'(th_hi) - int'($urandom_range(0, 7000)) + 1000);
      end
      if ($urandom_range(0, 19) == 0) v = int'($urandom_range(0, 24000)) - 12000;
      else v = v + int'($urandom_range(0, 1600)) - 800;
      if (v > 16000) v = 16000;
      if (v < -16000) v = -16000;
      step(v, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end

    // Reset held mid-stream clears everything and re-arms the first flag
    do_reset(10);
    th_hi = 16'sd4096;
    th_lo = 16'sd0;
    settle();
    chk("rst_spike", spike, 0);
    chk("rst_count", spike_count, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_isi", ev_isi, 0);
    chk("rst_ev_peak", longint'($signed(ev_peak)), 0);
    chk("rst_ev_first", ev_first, 0);
    chk("rst_overflow", overflow, 0);
    step(8192, 1'b1, 1'b0);
    step(-100, 1'b1, 1'b0);
    repeat (2) step(0, 1'b0, 1'b0);
    settle();
    chk("rst_rearm_valid", ev_valid, 1);
    chk("rst_rearm_first", ev_first, 1);
    chk("rst_rearm_isi", ev_isi, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fhn_spike_detector.md
Name: fhn_spike_detector

Overview:
Downstream consumer of the FHN neuron core's membrane output `v`. Sits directly after the core.
- Converts the continuous Q4.12 membrane trace into discrete spike events, using hysteresis thresholds and a refractory hold-off.
- Measures inter-spike interval (ISI) and per-spike peak amplitude.
- Queues one event per spike in a small FIFO with valid/ready output, for a host or readout stage.

Parameters:
- DW, 16, width of v_in, thresholds and peak (signed Q4.12).
- CW, 16, width of ISI and spike counters (unsigned, saturating).
- REFRACT, 8, samples held in REFRACT after a falling crossing; 0 = no hold-off.
- DEPTH, 4, event FIFO depth (power of two, ≥2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset (see below).
- v_in, input, DW, membrane potential from core, signed Q4.12.
- v_valid, input, 1, v_in is a new sample this cycle.
- th_hi, input, DW, rising threshold, signed.
- th_lo, input, DW, falling threshold, signed.
- spike, output, 1, one-cycle pulse per rising crossing.
- spike_count, output, CW, total spikes since reset, saturating.
- ev_valid, output, 1, FIFO head event available.
- ev_ready, input, 1, consumer accepts head event.
- ev_isi, output, CW, ISI of head event in samples.
- ev_peak, output, DW, peak v of head event.
- ev_first, output, 1, head event is the first since reset (ISI measured from reset).
- overflow, output, 1, sticky: an event was dropped because the FIFO was full.

Behaviour:
Reset:
- One clock; reset is asynchronous and active-high.
- rst clears every register: state=BELOW, spike=0, spike_count=0, ISI counter=0, peak=0, FIFO empty, ev_valid=0, ev_isi/ev_peak/ev_first=0, overflow=0, first-flag=1.
- Reset mid-operation discards any pending or queued events.

Sampling:
- All decisions happen only on cycles with v_valid=1. With v_valid=0, state and counters hold and spike=0.
- Comparisons are signed, full DW, against the live th_hi/th_lo values.
- th_lo ≥ th_hi is not checked; the FSM still follows the rules below.

FSM (states BELOW, ABOVE, REFRACT):
- BELOW:
  - If v_in ≥ th_hi, go to ABOVE.
  - spike=1 on the next cycle (1-cycle registered latency).
  - spike_count++ (saturates at all-ones).
  - latched_isi = min(cnt+1, max); cnt=0; peak = v_in.
  - Otherwise cnt++ (saturating).
- ABOVE:
  - cnt++ on every sample; peak = max(peak, v_in).
  - If v_in < th_lo, push {latched_isi, peak, first-flag} to the FIFO and clear first-flag.
  - Then go to REFRACT if REFRACT>0, else to BELOW.
  - The sample that causes the falling crossing is included in the peak comparison.
- REFRACT:
  - Down-counter loaded with REFRACT on entry; decrements per sample while cnt++ continues.
  - Leave to BELOW when the counter reaches 1 on a sample, i.e. exactly REFRACT samples spent in REFRACT.
  - Threshold crossings are ignored while in REFRACT.

FIFO:
- Push is registered; ev_valid rises the cycle after the push edge.
- A pop occurs when ev_valid && ev_ready.
- Push while full: if a pop happens the same cycle, the push succeeds. Otherwise the event is dropped and overflow=1 (sticky until rst).
- ev_* outputs are the head entry and hold stable while ev_valid=1 && ev_ready=0.
- Pointers wrap modulo DEPTH and use an extra bit for full/empty detection.

Decomposition:
- Shared package `fhn_pkg`:
  - Q4.12 constants: FRAC_BITS=12, ONE=4096.
  - Default thresholds.
  - State enum {BELOW, ABOVE, REFRACT}.
  - Event struct {first, isi, peak}.
- Sub-module `fhn_event_fifo`: synchronous FIFO, parameter DEPTH and width, ports push/din/full/pop/dout/empty, asynchronous active-high rst.

Test Plan:
1. rst held 10 cycles mid-stream, then released → all outputs 0, ev_valid=0, overflow=0, first-flag re-armed.
2. th_hi=4096, th_lo=0, REFRACT=8; ramp v_in from −4915 to 8192 and back to −4915 → one spike pulse; event with peak=8192, ev_first=1; spike_count=1.
3. Periodic waveform crossing th_hi every 100 valid samples, 3 periods → spike_count=3; events 2 and 3 have ev_isi=100, ev_first=0.
4. Noise: v_in toggles 4000↔4200 around th_hi=4096, th_lo=0 → exactly one spike (hysteresis holds); no event until v_in < 0.
5. Crossing of th_hi during REFRACT → no spike; after 8 samples, a crossing spikes normally.
6. ev_ready=0, DEPTH=4, 6 spikes → 4 events retained in order, overflow=1. Then ev_ready=1 → 4 pops, data stable between pops, ev_valid drops after the 4th. Plus a push on the same cycle as a pop while full → accepted.
